// File: rtl/tank_sprite_pkg.sv
// Shared constants and state type for the two-tank sprite controller.
// The sprite ROM holds the tank1 image first and the tank2 image directly after it.
package tank_sprite_pkg;

    localparam int unsigned SPR_W      = 36;
    localparam int unsigned SPR_H      = 36;
    localparam int unsigned SPR_PIXELS = SPR_W * SPR_H;
    localparam int unsigned TANK1_BASE = 0;
    localparam int unsigned TANK2_BASE = SPR_PIXELS;

    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } frame_state_t;

endpackage

// File: rtl/tank_sprite_ctrl_if.sv
// Sprite ROM port: the controller drives a registered address, and the ROM
// (clocked on the falling edge) returns a 4-bit palette index.
interface tank_sprite_ctrl_if #(
    parameter int ADDR_W = 12
);

    logic [ADDR_W-1:0] rom_address;
    logic [3:0]        rom_q;

    modport master (output rom_address, input rom_q);
    modport slave  (input rom_address, output rom_q);

endinterface

// File: rtl/sprite_hit_calc.sv
// Box test and ROM address for one sprite. The box edges are computed in
// 11 bits, so a sprite near x/y = 1023 never wraps around to column/row 0.
module sprite_hit_calc
    import tank_sprite_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              en,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic [ADDR_W-1:0] base,
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);

    logic [10:0] x_lo, x_hi, y_lo, y_hi, px, py, dx, dy;

    assign x_lo = {1'b0, pos_x};
    assign y_lo = {1'b0, pos_y};
    assign x_hi = x_lo + 11'(SPR_W);
    assign y_hi = y_lo + 11'(SPR_H);
    assign px   = {1'b0, draw_x};
    assign py   = {1'b0, draw_y};
    assign dx   = px - x_lo;
    assign dy   = py - y_lo;

    assign hit  = en && (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);

    assign addr = hit ? base + ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx) : '0;

endmodule

// File: rtl/tank_sprite_ctrl.sv
// Two-tank sprite controller: shadowed positions, tank1-priority arbitration
// onto one shared ROM, a two-stage pixel pipeline and a per-frame overlap count.
module tank_sprite_ctrl
    import tank_sprite_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                vga_clk,
    input  logic                Reset,
    input  logic                frame_start,
    input  logic                blank,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic [9:0]          tank1_x,
    input  logic [9:0]          tank1_y,
    input  logic [9:0]          tank2_x,
    input  logic [9:0]          tank2_y,
    input  logic                tank1_en,
    input  logic                tank2_en,
    tank_sprite_ctrl_if.master  rom,
    output logic [3:0]          sprite_index,
    output logic                sprite_hit,
    output logic                overlap,
    output logic [10:0]         overlap_count
);

    frame_state_t state;

    logic [9:0]  sh1_x, sh1_y, sh2_x, sh2_y;
    logic        sh1_en, sh2_en;
    logic        hit1, hit2;
    logic [ADDR_W-1:0] addr1, addr2;
    logic        hit_any, blank_d;
    logic [10:0] acc;
    logic        counted;

    sprite_hit_calc #(.ADDR_W(ADDR_W)) u_calc1 (
        .en     (sh1_en),
        .pos_x  (sh1_x),
        .pos_y  (sh1_y),
        .draw_x (DrawX),
        .draw_y (DrawY),
        .base   (ADDR_W'(TANK1_BASE)),
        .hit    (hit1),
        .addr   (addr1)
    );

    sprite_hit_calc #(.ADDR_W(ADDR_W)) u_calc2 (
        .en     (sh2_en),
        .pos_x  (sh2_x),
        .pos_y  (sh2_y),
        .draw_x (DrawX),
        .draw_y (DrawY),
        .base   (ADDR_W'(TANK2_BASE)),
        .hit    (hit2),
        .addr   (addr2)
    );

    assign counted = (state == RUN) && blank && hit1 && hit2;

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state         <= WAIT_FRAME;
            sh1_x         <= '0;
            sh1_y         <= '0;
            sh2_x         <= '0;
            sh2_y         <= '0;
            sh1_en        <= 1'b0;
            sh2_en        <= 1'b0;
            rom.rom_address <= '0;
            hit_any       <= 1'b0;
            blank_d       <= 1'b0;
            sprite_index  <= '0;
            sprite_hit    <= 1'b0;
            acc           <= '0;
            overlap       <= 1'b0;
            overlap_count <= '0;
        end else begin
            case (state)
                WAIT_FRAME: if (frame_start) state <= RUN;
                RUN:        state <= RUN;
                default:    state <= WAIT_FRAME;
            endcase

            if (frame_start) begin
                sh1_x  <= tank1_x;
                sh1_y  <= tank1_y;
                sh2_x  <= tank2_x;
                sh2_y  <= tank2_y;
                sh1_en <= tank1_en;
                sh2_en <= tank2_en;
            end

            // Tank1 wins the single ROM read even when its texel turns out transparent.
            rom.rom_address <= hit1 ? addr1 : (hit2 ? addr2 : '0);
            hit_any         <= (state == RUN) && (hit1 || hit2);
            blank_d         <= blank;

            sprite_index <= rom.rom_q;
            sprite_hit   <= hit_any && blank_d && (rom.rom_q != TRANSPARENT_IDX);

            // A pixel counted on the frame_start cycle belongs to the new frame.
            if (frame_start) begin
                overlap_count <= acc;
                overlap       <= (acc != '0);
                acc           <= counted ? 11'd1 : 11'd0;
            end else if (counted && (acc != '1)) begin
                acc <= acc + 11'd1;
            end
        end
    end

endmodule

// File: tb/tb_tank_sprite_ctrl.sv
// Directed bench for tank_sprite_ctrl with a falling-edge ROM model.
module tb_tank_sprite_ctrl;

    logic        vga_clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic        blank;
    logic [9:0]  DrawX, DrawY;
    logic [9:0]  tank1_x, tank1_y, tank2_x, tank2_y;
    logic        tank1_en, tank2_en;
    logic [3:0]  sprite_index;
    logic        sprite_hit;
    logic        overlap;
    logic [10:0] overlap_count;
    logic [3:0]  rom_fill;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    tank_sprite_ctrl_if #(.ADDR_W(12)) rom_bus ();

    tank_sprite_ctrl #(.ADDR_W(12)) dut (
        .vga_clk       (vga_clk),
        .Reset         (Reset),
        .frame_start   (frame_start),
        .blank         (blank),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .tank1_x       (tank1_x),
        .tank1_y       (tank1_y),
        .tank2_x       (tank2_x),
        .tank2_y       (tank2_y),
        .tank1_en      (tank1_en),
        .tank2_en      (tank2_en),
        .rom           (rom_bus.master),
        .sprite_index  (sprite_index),
        .sprite_hit    (sprite_hit),
        .overlap       (overlap),
        .overlap_count (overlap_count)
    );

    always #5 vga_clk = ~vga_clk;

    // ROM model: latches on the falling edge, returns a bench-chosen index.
    always @(negedge vga_clk) rom_bus.rom_q <= rom_fill;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic pixel(input int x, input int y, input logic b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pulse_frame();
        blank       = 1'b0;
        frame_start = 1'b1;
        @(posedge vga_clk);
        #1;
        frame_start = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; frame_start = 1'b0; blank = 1'b0;
        DrawX = '0; DrawY = '0;
        tank1_x = '0; tank1_y = '0; tank2_x = '0; tank2_y = '0;
        tank1_en = 1'b0; tank2_en = 1'b0;
        rom_fill = 4'h5;
        repeat (2) @(posedge vga_clk);
        #1;
        check("rst_addr", rom_bus.rom_address, 0);
        check("rst_index", sprite_index, 0);
        check("rst_hit", sprite_hit, 0);
        check("rst_overlap", overlap, 0);
        check("rst_count", overlap_count, 0);

        // No frame_start yet: shadows invalid, nothing may hit.
        Reset = 1'b0;
        tank1_x = 10'd100; tank1_y = 10'd50; tank1_en = 1'b1;
        pixel(100, 50, 1);
        pixel(110, 60, 1);
        check("wait_hit", sprite_hit, 0);
        check("wait_addr", rom_bus.rom_address, 0);
        pixel(120, 70, 1);
        check("wait_hit2", sprite_hit, 0);
        check("wait_count", overlap_count, 0);

        // Tank1 corners.
        pulse_frame();
        pixel(100, 50, 1);
        check("t1_tl_addr", rom_bus.rom_address, 0);
        pixel(135, 85, 1);
        check("t1_br_addr", rom_bus.rom_address, 1295);
        check("t1_tl_index", sprite_index, 5);
        check("t1_tl_hit", sprite_hit, 1);
        pixel(136, 50, 1);
        check("t1_out_addr", rom_bus.rom_address, 0);
        check("t1_br_hit", sprite_hit, 1);
        pixel(101, 50, 1);
        check("t1_col1_addr", rom_bus.rom_address, 1);
        check("t1_out_hit", sprite_hit, 0);
        pixel(102, 50, 0);
        check("blank_addr", rom_bus.rom_address, 2);
        pixel(103, 50, 1);
        check("blank_hit", sprite_hit, 0);
        check("blank_addr2", rom_bus.rom_address, 3);

        // Tank2 base offset.
        tank2_x = 10'd300; tank2_y = 10'd200; tank2_en = 1'b1;
        pulse_frame();
        check("t2_prev_ovl", overlap, 0);
        pixel(301, 201, 1);
        check("t2_addr", rom_bus.rom_address, 1333);

        // Tearing: new x only applies after the next frame_start.
        tank1_x = 10'd200;
        pixel(101, 51, 1);
        check("tear_old_addr", rom_bus.rom_address, 37);
        pixel(201, 51, 1);
        check("tear_new_miss", rom_bus.rom_address, 0);
        pulse_frame();
        pixel(201, 51, 1);
        check("tear_new_addr", rom_bus.rom_address, 37);
        pixel(101, 51, 1);
        check("tear_old_miss", rom_bus.rom_address, 0);

        // Priority, transparency and overlap count over a fully shared box.
        tank1_x = 10'd10; tank1_y = 10'd10;
        tank2_x = 10'd10; tank2_y = 10'd10;
        rom_fill = 4'h0;
        pulse_frame();
        check("pri_prev_count", overlap_count, 0);
        for (int y = 10; y < 46; y++) begin
            for (int x = 10; x < 46; x++) begin
                pixel(x, y, 1);
                if (y == 10 && x == 10) check("pri_addr0", rom_bus.rom_address, 0);
                if (y == 10 && x == 11) begin
                    check("pri_addr1", rom_bus.rom_address, 1);
                    check("transp_hit", sprite_hit, 0);
                end
            end
        end
        pulse_frame();
        check("ovl_count", overlap_count, 1296);
        check("ovl_flag", overlap, 1);

        // Sprite near the right edge: no wrap into low columns.
        tank1_x = 10'd1000; tank1_y = 10'd0; tank2_en = 1'b0;
        rom_fill = 4'h5;
        pulse_frame();
        pixel(5, 0, 1);
        check("edge_nowrap_addr", rom_bus.rom_address, 0);
        pixel(11, 0, 1);
        check("edge_nowrap_hit", sprite_hit, 0);
        pixel(1023, 0, 1);
        check("edge_1023_addr", rom_bus.rom_address, 23);
        pixel(1010, 1, 1);
        check("edge_addr", rom_bus.rom_address, 46);
        check("edge_hit", sprite_hit, 1);

        // Mid-frame reset clears everything on the next edge.
        Reset = 1'b1;
        pixel(1011, 1, 1);
        check("mid_rst_addr", rom_bus.rom_address, 0);
        check("mid_rst_hit", sprite_hit, 0);
        check("mid_rst_index", sprite_index, 0);
        check("mid_rst_ovl", overlap, 0);
        check("mid_rst_count", overlap_count, 0);
        Reset = 1'b0;
        pixel(1010, 1, 1);
        check("post_rst_addr", rom_bus.rom_address, 0);
        pixel(1012, 1, 1);
        check("post_rst_hit", sprite_hit, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
